// File: rtl/pipeline_types.sv
// pipeline_types: shared rename/commit types and default sizing.
//   N_PHYS     - default physical register count
//   PREG_W     - physical register index width
//   FIFO_DEPTH - default free-buffer depth
//   P0_PHYS    - hardwired-zero physical register, never freed
//   preg_t     - physical register index type
package pipeline_types;
    localparam int N_PHYS = 64;
    localparam int PREG_W = $clog2(N_PHYS);
    localparam int FIFO_DEPTH = 8;
    localparam int P0_PHYS = 0;
    typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/free_fifo_2w1r.sv
// free_fifo_2w1r: circular buffer taking up to two writes and one read per cycle.
//   clk, rst       - clock, synchronous active-high reset
//   wa_en, wa_data - first write, lands at the write pointer
//   wb_en, wb_data - second write, lands after the first one
//   rd_en          - pop the head entry
//   rd_data        - current head entry
//   count          - entries held
//   space          - free slots
//   empty          - no entries held
module free_fifo_2w1r #(
    parameter int W = 6,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wa_en,
    input  logic [W-1:0]  wa_data,
    input  logic          wb_en,
    input  logic [W-1:0]  wb_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic [CW-1:0] space,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign space = CW'(DEPTH) - count;
    assign empty = count == '0;

    always_ff @(posedge clk) begin
        if (wa_en) mem[wr_ptr] <= wa_data;
        if (wb_en) mem[wr_ptr + AW'(wa_en)] <= wb_data;
    end

    // count is tracked apart from the pointers so full and empty differ
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wa_en) + AW'(wb_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + CW'(wa_en) + CW'(wb_en) - CW'(rd_en);
        end
    end
endmodule

// File: rtl/free_return_arbiter.sv
// free_return_arbiter: merges two ROB commit-free lanes into rename's single free port.
//   clk, rst                         - clock, synchronous active-high reset
//   commit0_valid_i, commit0_preg_i  - older lane free
//   commit1_valid_i, commit1_preg_i  - younger lane free
//   commit_ready_o                   - room for two frees this cycle
//   recover_i                        - rename checkpoint recovery, holds delivery
//   free_valid_o, free_preg_o        - one free per cycle to rename
//   occupancy_o                      - entries buffered
//   overflow_err_o                   - sticky dropped-enqueue flag
module free_return_arbiter #(
    parameter int N_PHYS = pipeline_types::N_PHYS,
    parameter int FIFO_DEPTH = pipeline_types::FIFO_DEPTH,
    parameter int P0_PHYS = pipeline_types::P0_PHYS,
    localparam int PREG_W = $clog2(N_PHYS),
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit0_valid_i,
    input  logic [PREG_W-1:0] commit0_preg_i,
    input  logic              commit1_valid_i,
    input  logic [PREG_W-1:0] commit1_preg_i,
    output logic              commit_ready_o,
    input  logic              recover_i,
    output logic              free_valid_o,
    output logic [PREG_W-1:0] free_preg_o,
    output logic [CW-1:0]     occupancy_o,
    output logic              overflow_err_o
);
    logic q0, q1, hold, deq, recover_q, wa_en, wb_en, empty;
    logic [PREG_W-1:0] head;
    logic [CW-1:0] count, space, credit;
    logic [1:0] enq_n;

    // credit counts the slot freed by this cycle's dequeue; when short,
    // the older lane wins the single remaining slot
    always_comb begin
        q0 = commit0_valid_i && commit0_preg_i != PREG_W'(P0_PHYS);
        q1 = commit1_valid_i && commit1_preg_i != PREG_W'(P0_PHYS);
        hold = recover_i | recover_q;
        deq = !hold && !empty;
        credit = space + CW'(deq);
        enq_n = 2'(q0) + 2'(q1);
        wa_en = (q0 | q1) && credit != '0;
        wb_en = q0 && q1 && credit >= CW'(2);
    end

    assign commit_ready_o = space >= CW'(2);
    assign occupancy_o = count;

    free_fifo_2w1r #(.W(PREG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wa_en(wa_en),
        .wa_data(q0 ? commit0_preg_i : commit1_preg_i),
        .wb_en(wb_en),
        .wb_data(commit1_preg_i),
        .rd_en(deq),
        .rd_data(head),
        .count(count),
        .space(space),
        .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            recover_q      <= 1'b0;
            free_valid_o   <= 1'b0;
            free_preg_o    <= '0;
            overflow_err_o <= 1'b0;
        end else begin
            recover_q    <= recover_i;
            free_valid_o <= deq;
            if (deq) free_preg_o <= head;
            if (CW'(enq_n) > credit) overflow_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_free_return_arbiter.sv
// tb_free_return_arbiter: directed tables, corner sequences and random traffic against a queue model.
module tb_free_return_arbiter;
    localparam int DEPTH = 8;

    logic clk = 0, rst = 1, c0v = 0, c1v = 0, rec = 0;
    logic [5:0] c0p = 0, c1p = 0, fp;
    logic ready, fv, ovf;
    logic [3:0] occ;
    int n_chk = 0, n_pass = 0;

    int mq[$];
    bit m_valid, m_ovf, m_recq;
    int m_preg;

    typedef struct {
        bit v0; int p0; bit v1; int p1;
        bit ev; int ep; int eo;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    free_return_arbiter dut (
        .clk(clk),
        .rst(rst),
        .commit0_valid_i(c0v),
        .commit0_preg_i(c0p),
        .commit1_valid_i(c1v),
        .commit1_preg_i(c1p),
        .commit_ready_o(ready),
        .recover_i(rec),
        .free_valid_o(fv),
        .free_preg_o(fp),
        .occupancy_o(occ),
        .overflow_err_o(ovf)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // frees leave in arrival order; the dequeued slot is reusable the same
    // cycle, and each lane in turn is kept only if the buffer still has room
    task automatic model(input bit rs, input bit v0, input int p0, input bit v1, input int p1, input bit r);
        if (rs) begin
            mq.delete();
            m_valid = 0; m_preg = 0; m_ovf = 0; m_recq = 0;
            return;
        end
        if (!(r || m_recq) && mq.size() > 0) begin
            m_preg = mq.pop_front();
            m_valid = 1;
        end else m_valid = 0;
        if (v0 && p0 != 0) begin
            if (mq.size() < DEPTH) mq.push_back(p0); else m_ovf = 1;
        end
        if (v1 && p1 != 0) begin
            if (mq.size() < DEPTH) mq.push_back(p1); else m_ovf = 1;
        end
        m_recq = r;
    endtask

    task automatic step(input bit rs, input bit v0, input int p0, input bit v1, input int p1, input bit r);
        rst = rs; c0v = v0; c0p = 6'(p0); c1v = v1; c1p = 6'(p1); rec = r;
        model(rs, v0, p0 & 63, v1, p1 & 63, r);
        @(posedge clk);
        #1;
        chk("model_free_valid", int'(fv), int'(m_valid));
        chk("model_free_preg", int'(fp), m_preg);
        chk("model_occupancy", int'(occ), mq.size());
        chk("model_commit_ready", int'(ready), int'(DEPTH - mq.size() >= 2));
        chk("model_overflow_err", int'(ovf), int'(m_ovf));
    endtask

    task automatic idle(input bit r);
        step(0, 0, 0, 0, 0, r);
    endtask

    task automatic chk3(input string nm, input int ev, input int ep, input int eo);
        chk({nm, "_valid"}, int'(fv), ev);
        chk({nm, "_preg"}, int'(fp), ep);
        chk({nm, "_occ"}, int'(occ), eo);
    endtask

    initial begin
        tbl[0] = '{1, 40, 0, 0, 0, 0, 1};
        tbl[1] = '{0, 0, 0, 0, 1, 40, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 40, 0};
        tbl[3] = '{1, 33, 1, 34, 0, 40, 2};
        tbl[4] = '{0, 0, 0, 0, 1, 33, 1};
        tbl[5] = '{0, 0, 0, 0, 1, 34, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 34, 0};
        tbl[7] = '{1, 0, 1, 50, 0, 34, 1};
        tbl[8] = '{0, 0, 0, 0, 1, 50, 0};
        tbl[9] = '{0, 0, 0, 0, 0, 50, 0};

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk3("reset", 0, 0, 0);
        chk("reset_ready", int'(ready), 1);
        chk("reset_ovf", int'(ovf), 0);

        foreach (tbl[i]) begin
            step(0, tbl[i].v0, tbl[i].p0, tbl[i].v1, tbl[i].p1, 0);
            chk3($sformatf("tbl%0d", i), int'(tbl[i].ev), tbl[i].ep, tbl[i].eo);
        end

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 41, 1, 42, 0);
        step(0, 1, 43, 0, 0, 0);
        chk3("rec_emit41", 1, 41, 2);
        idle(1);
        chk3("rec_hold1", 0, 41, 2);
        step(0, 1, 44, 0, 0, 0);
        chk3("rec_hold2", 0, 41, 3);
        idle(0);
        chk3("rec_emit42", 1, 42, 2);
        idle(0);
        chk3("rec_emit43", 1, 43, 1);
        idle(0);
        chk3("rec_emit44", 1, 44, 0);
        idle(0);
        chk3("rec_done", 0, 44, 0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 2, 1);
        step(0, 1, 3, 1, 4, 1);
        step(0, 1, 5, 1, 6, 1);
        chk("full_ready_at6", int'(ready), 1);
        step(0, 1, 7, 1, 8, 1);
        chk("full_ready_at8", int'(ready), 0);
        chk("full_occ8", int'(occ), 8);
        chk("full_ovf_before", int'(ovf), 0);
        step(0, 1, 9, 1, 10, 1);
        chk("full_ovf_after", int'(ovf), 1);
        chk("full_occ_kept", int'(occ), 8);
        idle(0);
        chk("full_recq_hold", int'(fv), 0);
        for (int k = 1; k <= 8; k++) begin
            idle(0);
            chk($sformatf("full_drain%0d_valid", k), int'(fv), 1);
            chk($sformatf("full_drain%0d_preg", k), int'(fp), k);
        end
        idle(0);
        chk3("full_empty", 0, 8, 0);
        chk("full_ovf_sticky", int'(ovf), 1);

        step(0, 1, 11, 1, 12, 1);
        step(0, 1, 13, 1, 14, 1);
        step(0, 1, 15, 0, 0, 1);
        idle(0);
        chk("rstmid_occ5", int'(occ), 5);
        step(1, 0, 0, 0, 0, 0);
        chk("rstmid_valid", int'(fv), 0);
        chk("rstmid_occ", int'(occ), 0);
        chk("rstmid_ready", int'(ready), 1);
        chk("rstmid_ovf", int'(ovf), 0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(9) < 6, ($urandom_range(7) == 0) ? 0 : int'($urandom_range(63)),
                 $urandom_range(9) < 6, ($urandom_range(7) == 0) ? 0 : int'($urandom_range(63)),
                 (i % 100 < 15) || ($urandom_range(9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/free_return_arbiter.md
Name: free_return_arbiter

Overview:
Merges physical-register frees from the two ROB commit lanes into the rename stage's single commit-free port, which accepts at most one free per cycle. An elastic FIFO decouples the two sides, and commit_ready_o backpressures the ROB. Frees are withheld while rename performs checkpoint recovery, so no free is delivered in a cycle where rename overwrites its freelist tail. Sits between ROB commit and rename.

Parameters:
N_PHYS, 64, physical register count; PREG_W = $clog2(N_PHYS)
FIFO_DEPTH, 8, free-buffer entries; power of two, >= 4
P0_PHYS, 0, hardwired-zero physical register; never returned

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
commit0_valid_i  in  1  ROB lane 0 (older) frees a preg
commit0_preg_i  in  PREG_W  preg freed by lane 0
commit1_valid_i  in  1  ROB lane 1 (younger) frees a preg
commit1_preg_i  in  PREG_W  preg freed by lane 1
commit_ready_o  out  1  ROB may commit up to two frees this cycle
recover_i  in  1  rename misprediction recovery (same signal rename sees)
free_valid_o  out  1  to rename rob_commit_free_valid_i
free_preg_o  out  PREG_W  to rename rob_commit_free_preg_i
occupancy_o  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
overflow_err_o  out  1  sticky: an enqueue was dropped for lack of space

Behaviour:
- Reset values: free_valid_o=0, free_preg_o=0, occupancy_o=0, overflow_err_o=0, commit_ready_o=1. Reset clears the FIFO and the hold register. Reset mid-operation discards all buffered frees.
- Filtering: a lane with valid=1 and preg==P0_PHYS is ignored. It is not enqueued and does not count against space.
- Enqueue order: lane 0 is written before lane 1. One or two entries are written per cycle; wr_ptr advances by the number written, mod FIFO_DEPTH.
- commit_ready_o = (FIFO_DEPTH - count) >= 2. This is combinational from registered count only. It does not consider a same-cycle dequeue.
- Overflow: if the qualified enqueues in a cycle exceed the free slots (dequeue credit included):
  - write the lane-0 entry if one slot remains;
  - drop the rest;
  - set overflow_err_o (cleared only by rst).
- hold = recover_i | recover_q, where recover_q is recover_i registered one cycle.
- Dequeue: at each edge, if !hold and count>0, load the output register with the FIFO head, set free_valid_o=1, and advance rd_ptr. Otherwise free_valid_o=0 at that edge.
- free_valid_o is high for exactly one cycle per entry. Rename has no ready; each valid cycle is a consumed free.
- Latency: a free enqueued at edge N drives free_valid_o from edge N+1 at the earliest.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq. With count==FIFO_DEPTH, one dequeue plus one enqueue is legal.
- Empty FIFO plus enqueue: no combinational bypass; the one-cycle latency still applies.
- Recovery: while hold=1, the FIFO retains all entries and continues to accept enqueues. free_valid_o is forced low from the edge at which recover_i is sampled high. Delivery resumes at the second edge after recover_i falls.
- Wrap-around: pointers are PREG-independent, $clog2(FIFO_DEPTH) bits, and wrap naturally. count is kept separately, so a full FIFO and an empty FIFO are distinguishable.
- occupancy_o = count (registered).

Decomposition:
- Shared package (pipeline_types):
  - typedef preg_t = logic [PREG_W-1:0];
  - constant P0_PHYS.
- One natural sub-module, free_fifo_2w1r: 2-write/1-read circular buffer with count, full-space, and empty outputs.
- The top level holds filtering, overflow logic, hold, and the output register.

Test Plan:
- Single free: commit0 preg=40 at cycle 0 → free_valid_o=1, free_preg_o=40 in cycle 1 only; occupancy returns to 0.
- Dual commit ordering: lane0=33, lane1=34 in one cycle → outputs 33 then 34 on consecutive cycles; occupancy peaks at 2.
- P0 filter: lane0=0, lane1=50 → only 50 emitted; occupancy max 1.
- Backpressure/full: dual-commit 4 cycles, FIFO_DEPTH=8 → commit_ready_o=0 once count≥7. A forced extra dual enqueue at count=8 with no dequeue sets overflow_err_o=1 and keeps the first 8 values intact.
- Recovery hold: 3 buffered (41,42,43); recover_i pulsed for 1 cycle after 41 is emitted → no valid for 2 cycles, then 42, 43. An enqueue of 44 during hold appears after 43.
- Reset mid-drain: rst asserted with 5 entries → next cycle free_valid_o=0, occupancy_o=0, commit_ready_o=1, overflow_err_o=0.
